// File: rtl/pc_sequencer_pkg.sv
// ============================================================================
// Module  : pc_sequencer_pkg
// Brief   : Shared sequencer state encoding, width defaults, decoder opcodes.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pc_sequencer_pkg;

    localparam int C_PC_W_DEFAULT  = 10;
    localparam int C_KEY_W_DEFAULT = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // Opcode field values produced by the instruction decoder
    localparam logic [3:0] C_OP_NOP    = 4'h0;
    localparam logic [3:0] C_OP_ALU    = 4'h1;
    localparam logic [3:0] C_OP_LOAD   = 4'h2;
    localparam logic [3:0] C_OP_STORE  = 4'h3;
    localparam logic [3:0] C_OP_BRANCH = 4'h4;
    localparam logic [3:0] C_OP_HALT   = 4'hF;

    function automatic logic is_active(input seq_state_t s);
        return (s == ST_RUN) || (s == ST_STALL);
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_lut.sv
// ============================================================================
// Module  : branch_lut
// Brief   : Branch target table, one synchronous write and one async read.
// Revision: 1.0
// ============================================================================
`default_nettype none

module branch_lut #(
    parameter int KEY_W = 5,
    parameter int PC_W  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [KEY_W-1:0] i_wr_key,
    input  logic [PC_W-1:0]  i_wr_target,
    input  logic [KEY_W-1:0] i_rd_key,
    output logic [PC_W-1:0]  o_rd_target
);

    logic [PC_W-1:0] r_mem [2**KEY_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**KEY_W; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_key] <= i_wr_target;
        end
    end

    // Read bypasses nothing: a same-cycle write is seen only after the edge
    assign o_rd_target = r_mem[i_rd_key];

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module  : pc_sequencer
// Brief   : Program-counter FSM with stall, halt and LUT-based branching.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int PC_W  = C_PC_W_DEFAULT,
    parameter int KEY_W = C_KEY_W_DEFAULT,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             branch_en,
    input  logic [KEY_W-1:0] branch_key,
    input  logic             halt,
    input  logic             mem_busy,
    input  logic             lut_wr_en,
    input  logic [KEY_W-1:0] lut_wr_key,
    input  logic [PC_W-1:0]  lut_wr_target,
    output logic [PC_W-1:0]  pc,
    output logic             fetch_en,
    output logic             running,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  w_pc_nxt;
    logic [PC_W-1:0]  w_lut_target;
    logic [CNT_W-1:0] r_cycle_count;
    logic [CNT_W-1:0] w_count_nxt;

    branch_lut #(
        .KEY_W (KEY_W),
        .PC_W  (PC_W)
    ) u_branch_lut (
        .clk         (clk),
        .rst         (reset),
        .i_wr_en     (lut_wr_en),
        .i_wr_key    (lut_wr_key),
        .i_wr_target (lut_wr_target),
        .i_rd_key    (branch_key),
        .o_rd_target (w_lut_target)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_pc          <= '0;
            r_cycle_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_cycle_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_count_nxt = r_cycle_count;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = '0;
                    w_count_nxt = '0;
                end
            end
            // A stalled instruction is re-evaluated with the same rules once memory frees up
            ST_RUN, ST_STALL: begin
                if (r_cycle_count != C_CNT_MAX) begin
                    w_count_nxt = r_cycle_count + 1'b1;
                end
                if (mem_busy) begin
                    w_state_nxt = ST_STALL;
                end else if (halt) begin
                    w_state_nxt = ST_DONE;
                end else if (branch_en) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = w_lut_target;
                end else begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = r_pc + 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign pc          = r_pc;
    assign fetch_en    = (r_state == ST_RUN);
    assign running     = is_active(r_state);
    assign done        = (r_state == ST_DONE);
    assign cycle_count = r_cycle_count;

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_W, default 10, program-counter width in bits.
REQ-002 Parameter KEY_W, default 5, branch-key width in bits; the branch LUT holds 2**KEY_W entries.
REQ-003 Parameter CNT_W, default 16, cycle-counter width in bits.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  pulse that begins program execution.
REQ-007 branch_en  in  1  taken-branch indication from the decoder for the current instruction.
REQ-008 branch_key  in  KEY_W  LUT index selecting the branch target.
REQ-009 halt  in  1  decoded halt instruction.
REQ-010 mem_busy  in  1  data memory not ready; current instruction must hold.
REQ-011 lut_wr_en  in  1  branch-LUT write strobe.
REQ-012 lut_wr_key  in  KEY_W  LUT entry to write.
REQ-013 lut_wr_target  in  PC_W  target value to write.
REQ-014 pc  out  PC_W  address of the instruction currently presented to the decoder.
REQ-015 fetch_en  out  1  instruction memory read enable.
REQ-016 running  out  1  high while in RUN or STALL.
REQ-017 done  out  1  one-cycle pulse on program completion.
REQ-018 cycle_count  out  CNT_W  number of cycles spent in RUN or STALL since the last accepted start.

Function
REQ-019 The FSM SHALL have states IDLE, RUN, STALL and DONE.
REQ-020 IDLE: on start, go to RUN with pc=0 and cycle_count=0; otherwise hold pc.
REQ-021 RUN, mem_busy=1: go to STALL; pc holds; branch_en and halt are ignored this cycle.
REQ-022 RUN, mem_busy=0, halt=1: go to DONE; pc holds; halt has priority over branch_en.
REQ-023 RUN, mem_busy=0, halt=0, branch_en=1: pc loads lut[branch_key]; state stays RUN.
REQ-024 RUN, no other condition active: pc increments by 1 and wraps from 2**PC_W-1 to 0.
REQ-025 STALL: stays in STALL while mem_busy=1; on mem_busy=0, applies the REQ-022..024 rules to the held instruction in that same cycle.
REQ-026 DONE: done=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-027 fetch_en SHALL be 1 in RUN and 0 in STALL, IDLE and DONE.
REQ-028 running SHALL be 1 in RUN and STALL.
REQ-029 cycle_count increments once per RUN or STALL cycle, saturates at 2**CNT_W-1, and holds its value through DONE and IDLE until the next start.
REQ-030 start SHALL be ignored outside IDLE.
REQ-031 LUT writes are accepted in any state and take effect on the next edge.
REQ-032 A branch reading the same key that is written in the same cycle SHALL use the old value.
REQ-033 Inputs branch_en, branch_key and halt are combinational from the decoder and are sampled only on the edges defined above.

Reset
REQ-034 reset SHALL force state=IDLE, pc=0, done=0, fetch_en=0, running=0, cycle_count=0, and all LUT entries to 0.
REQ-035 reset SHALL take priority over every other input, including assertion mid-RUN or mid-STALL and assertion in the same cycle as start.

Structure
REQ-036 The FSM state enum and the PC_W and KEY_W defaults SHALL live in a shared package with the decoder's opcode constants.
REQ-037 The branch LUT SHALL be one sub-module, branch_lut, with one synchronous write port and one combinational read port.

Verification
REQ-038 Write lut[3]=0x040, start, execute 5 sequential instructions, then branch_en=1 with key=3 → pc sequence 0,1,2,3,4,5,0x040.
REQ-039 mem_busy=1 for 3 cycles at pc=2 → pc stays 2 for 4 cycles, fetch_en=0 for 3 cycles, cycle_count still increments.
REQ-040 halt=1 and branch_en=1 at pc=7 → pc stays 7, done pulses once, FSM returns to IDLE, and a further start restarts at pc=0.
REQ-041 Write lut[5]=0x100 while branching on key 5 (old value 0x020) → pc=0x020; a later branch on key 5 → pc=0x100.
REQ-042 Run from pc=0x3FE with no branches → pc sequence 0x3FE, 0x3FF, 0x000.
REQ-043 Assert reset mid-STALL → next cycle pc=0, running=0, lut[3]=0; a start pulse while running has no effect.
